// File: rtl/op_sequencer_if.sv
// Bundle between op_sequencer and its shared operation datapath / command source.
// The DUT (slave) takes commands and datapath results, and drives decoder controls and captured results.
interface op_sequencer_if #(
  parameter int W = 4
);
  // Command protocol: start is sampled only while the sequencer is idle.
  // The command is accepted in that same cycle; there is no ready signal.
  // done pulses for one cycle when the command completes.
  // start is ignored from acceptance until the idle cycle that follows done.
  logic           start;
  logic [3:0]     mask;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] res0;
  logic [2*W-1:0] res1;
  logic [2*W-1:0] res2;
  logic [2*W-1:0] res3;

  logic [1:0]     dec;
  logic           enable;
  logic [W-1:0]   opa;
  logic [W-1:0]   opb;
  logic [2*W-1:0] r0;
  logic [2*W-1:0] r1;
  logic [2*W-1:0] r2;
  logic [2*W-1:0] r3;
  logic [3:0]     validmask;
  logic           busy;
  logic           done;
  logic [1:0]     state;

  modport master (
    output start, mask, a, b, res0, res1, res2, res3,
    input  dec, enable, opa, opb, r0, r1, r2, r3, validmask, busy, done, state
  );

  modport slave (
    input  start, mask, a, b, res0, res1, res2, res3,
    output dec, enable, opa, opb, r0, r1, r2, r3, validmask, busy, done, state
  );
endinterface

// File: rtl/op_sequencer.sv
// Walks the set bits of a latched operation mask in ascending order.
// It drives one datapath operation per cycle and captures each result into its own register.
module op_sequencer #(
  parameter int W = 4
) (
  input  logic            clk,
  input  logic            rst,
  op_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [3:0]     mask_q;
  logic [W-1:0]   opa_q;
  logic [W-1:0]   opb_q;
  logic [2*W-1:0] r_q [4];
  logic [3:0]     valid_q;

  logic [1:0]     dec_pri;
  logic [3:0]     dec_onehot;
  logic [2*W-1:0] res_sel;
  logic           accept;
  logic           run_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    run_step  = 1'b0;
    dec_pri   = 2'd0;
    // Lowest set bit wins: scan downward so the last hit is the smallest index.
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i]) dec_pri = 2'(i);
    end
    dec_onehot = 4'b0001 << dec_pri;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = (bus.mask != 4'd0) ? RUN : FINISH;
        end
      end
      RUN: begin
        run_step = 1'b1;
        if ((mask_q & ~dec_onehot) == 4'd0) state_nxt = FINISH;
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    res_sel = bus.res0;
    case (dec_pri)
      2'd0: res_sel = bus.res0;
      2'd1: res_sel = bus.res1;
      2'd2: res_sel = bus.res2;
      2'd3: res_sel = bus.res3;
      default: res_sel = bus.res0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q  <= 4'd0;
      opa_q   <= '0;
      opb_q   <= '0;
      valid_q <= 4'd0;
      for (int i = 0; i < 4; i++) r_q[i] <= '0;
    end else begin
      if (accept) begin
        valid_q <= 4'd0;
        // An empty mask goes straight to FINISH and leaves the operands untouched.
        if (bus.mask != 4'd0) begin
          mask_q <= bus.mask;
          opa_q  <= bus.a;
          opb_q  <= bus.b;
        end
      end
      if (run_step) begin
        r_q[dec_pri]     <= res_sel;
        valid_q[dec_pri] <= 1'b1;
        mask_q[dec_pri]  <= 1'b0;
      end
    end
  end

  assign bus.dec       = (state == RUN) ? dec_pri : 2'd0;
  assign bus.enable    = (state == RUN);
  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == FINISH);
  assign bus.opa       = opa_q;
  assign bus.opb       = opb_q;
  assign bus.r0        = r_q[0];
  assign bus.r1        = r_q[1];
  assign bus.r2        = r_q[2];
  assign bus.r3        = r_q[3];
  assign bus.validmask = valid_q;
  assign bus.state     = state;

endmodule

// File: tb/tb_op_sequencer.sv
// Bench for op_sequencer: an abstract per-command schedule model compared every cycle.
// Directed scenarios add hand-computed literal expectations.
module tb_op_sequencer;
  localparam int W  = 4;
  localparam int RW = 2 * W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  op_sequencer_if #(.W(W)) bus ();
  op_sequencer #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Bench-side datapath: four distinct operations on the driven operands.
  assign bus.res0 = RW'(bus.opa) + RW'(bus.opb);
  assign bus.res1 = RW'(bus.opa) * RW'(bus.opb);
  assign bus.res2 = {bus.opa, bus.opb};
  assign bus.res3 = {bus.opb, bus.opa};

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [RW-1:0] model_res(input int idx, input int av, input int bv);
    case (idx)
      0:       return RW'(av + bv);
      1:       return RW'(av * bv);
      2:       return RW'(av * (1 << W) + bv);
      default: return RW'(bv * (1 << W) + av);
    endcase
  endfunction

  typedef struct packed {
    logic       enable;
    logic [1:0] dec;
    logic       busy;
    logic       done;
  } cyc_t;

  // One entry per future cycle of an accepted command; empty queue means idle.
  cyc_t           exp_q[$];
  logic [RW-1:0]  r_exp [4];
  logic [3:0]     vm_exp;
  logic [W-1:0]   opa_exp;
  logic [W-1:0]   opb_exp;
  logic           checking = 1'b0;
  cyc_t           cur;
  cyc_t           rec;
  logic           idle;

  always @(negedge clk) begin
    idle = 1'b1;
    cur  = '0;
    if (checking) begin
      if (exp_q.size() > 0) begin
        cur  = exp_q.pop_front();
        idle = 1'b0;
      end
      chk("enable", 32'(bus.enable), 32'(cur.enable));
      chk("dec", 32'(bus.dec), 32'(cur.dec));
      chk("busy", 32'(bus.busy), 32'(cur.busy));
      chk("done", 32'(bus.done), 32'(cur.done));
      chk("validmask", 32'(bus.validmask), 32'(vm_exp));
      chk("r0", 32'(bus.r0), 32'(r_exp[0]));
      chk("r1", 32'(bus.r1), 32'(r_exp[1]));
      chk("r2", 32'(bus.r2), 32'(r_exp[2]));
      chk("r3", 32'(bus.r3), 32'(r_exp[3]));
      chk("opa", 32'(bus.opa), 32'(opa_exp));
      chk("opb", 32'(bus.opb), 32'(opb_exp));
    end
    // Apply what the coming rising edge does, given the inputs now stable.
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < 4; i++) r_exp[i] = '0;
      vm_exp   = 4'd0;
      opa_exp  = '0;
      opb_exp  = '0;
      checking = 1'b1;
    end else if (checking) begin
      if (!idle && cur.enable) begin
        r_exp[cur.dec]  = model_res(int'(cur.dec), int'(opa_exp), int'(opb_exp));
        vm_exp[cur.dec] = 1'b1;
      end
      if (idle && bus.start) begin
        vm_exp = 4'd0;
        if (bus.mask != 4'd0) begin
          opa_exp = bus.a;
          opb_exp = bus.b;
        end
        for (int i = 0; i < 4; i++) begin
          if (bus.mask[i]) begin
            rec = '{enable: 1'b1, dec: 2'(i), busy: 1'b1, done: 1'b0};
            exp_q.push_back(rec);
          end
        end
        rec = '{enable: 1'b0, dec: 2'd0, busy: 1'b0, done: 1'b1};
        exp_q.push_back(rec);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a command in an idle cycle and returns the cycle count to done (0 = timeout).
  task automatic run_cmd(input logic [3:0] m, input int av, input int bv,
                         input bit repulse, output int lat);
    tick();
    bus.start = 1'b1;
    bus.mask  = m;
    bus.a     = W'(av);
    bus.b     = W'(bv);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      bus.start = 1'b0;
      bus.mask  = 4'($urandom_range(0, 15));
      bus.a     = W'($urandom_range(0, 15));
      bus.b     = W'($urandom_range(0, 15));
      if (repulse && n == 1) begin
        bus.start = 1'b1;
        bus.mask  = 4'b0001;
      end
      if (bus.done) begin
        lat = n;
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  int lat;
  int done_seen;

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.mask  = 4'd0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    done_seen = 0;
    repeat (6) begin
      tick();
      if (bus.done) done_seen++;
    end
    chk("rst_done_count", 32'(done_seen), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_validmask", 32'(bus.validmask), 32'd0);
    chk("rst_r3", 32'(bus.r3), 32'd0);

    // Full mask, A=3 B=5.
    run_cmd(4'b1111, 3, 5, 1'b0, lat);
    chk("lat_1111", 32'(lat), 32'd5);
    tick();
    chk("vm_1111", 32'(bus.validmask), 32'hF);
    chk("r0_1111", 32'(bus.r0), 32'h08);
    chk("r1_1111", 32'(bus.r1), 32'h0F);
    chk("r2_1111", 32'(bus.r2), 32'h35);
    chk("r3_1111", 32'(bus.r3), 32'h53);
    chk("opa_1111", 32'(bus.opa), 32'd3);
    chk("opb_1111", 32'(bus.opb), 32'd5);

    // Sparse mask: R0/R2 keep the previous command's results.
    run_cmd(4'b1010, 9, 2, 1'b0, lat);
    chk("lat_1010", 32'(lat), 32'd3);
    tick();
    chk("vm_1010", 32'(bus.validmask), 32'hA);
    chk("r0_kept", 32'(bus.r0), 32'h08);
    chk("r2_kept", 32'(bus.r2), 32'h35);
    chk("r1_1010", 32'(bus.r1), 32'h12);
    chk("r3_1010", 32'(bus.r3), 32'h29);

    // Empty mask: done one cycle after acceptance, validity cleared.
    run_cmd(4'b0000, 1, 1, 1'b0, lat);
    chk("lat_0000", 32'(lat), 32'd1);
    tick();
    chk("vm_0000", 32'(bus.validmask), 32'h0);
    chk("opa_0000_hold", 32'(bus.opa), 32'd9);

    // START re-pulsed during RUN is ignored.
    run_cmd(4'b0110, 4, 4, 1'b1, lat);
    chk("lat_0110", 32'(lat), 32'd3);
    tick();
    chk("vm_0110", 32'(bus.validmask), 32'h6);
    chk("busy_after_0110", 32'(bus.busy), 32'd0);

    // Reset in the second RUN cycle aborts with no DONE and no results.
    bus.start = 1'b1;
    bus.mask  = 4'b1111;
    bus.a     = W'(7);
    bus.b     = W'(6);
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_enable", 32'(bus.enable), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_vm", 32'(bus.validmask), 32'd0);
    chk("abort_r0", 32'(bus.r0), 32'd0);
    chk("abort_r1", 32'(bus.r1), 32'd0);
    done_seen = 0;
    repeat (5) begin
      if (bus.done) done_seen++;
      tick();
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);

    // Randomized traffic, including occasional reset and start during RUN/FINISH.
    for (int c = 0; c < 400; c++) begin
      bus.start = 1'($urandom_range(0, 1));
      bus.mask  = 4'($urandom_range(0, 15));
      bus.a     = W'($urandom_range(0, 15));
      bus.b     = W'($urandom_range(0, 15));
      rst       = ($urandom_range(0, 39) == 0);
      tick();
    end
    bus.start = 1'b0;
    rst       = 1'b0;
    repeat (8) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
